ca_prng_gen: RTL and testbench
==============================

// Module: ca_prng_gen
// PURPOSE
//   Parametrised hybrid rule-90/150 cellular-automaton pseudo-random word generator.
//   Uses null boundaries, a per-cell rule mask and a loadable seed.
//   Runs a job-based FSM that advances the CA STRIDE steps per output word.
//   Delivers words over a valid/ready handshake.
//   Sits in the approximate-multiplier test harness and feeds random operands to the multiplier under test.
// PARAMETERS
//   WIDTH         16       CA cell count = out_data width; legal range >= 4
//   RULE150_MASK  16'h5555 bit i=1: cell i uses rule 150; bit i=0: cell i uses rule 90 (WIDTH bits)
//   SEED_DEFAULT  16'h0001 CA state after reset, and substitute for any all-zero seed (must be nonzero)
//   STRIDE        1        CA steps per emitted word; legal range >= 1
//   CNT_W         16       width of num_words and word_cnt
// PORTS
//   clk        in   1      rising-edge clock
//   rst        in   1      asynchronous, active-low reset
//   seed_load  in   1      load seed into the CA; honoured only in IDLE
//   seed       in   WIDTH  seed value
//   start      in   1      begin a job; honoured only in IDLE
//   num_words  in   CNT_W  words per job, latched at start; 0 = free-run until abort
//   abort      in   1      terminate the current job
//   out_ready  in   1      consumer accepts out_data
//   out_valid  out  1      out_data holds a new word
//   out_data   out  WIDTH  generated word
//   busy       out  1      FSM not in IDLE
//   done       out  1      one-cycle pulse when a job completes normally
//   word_cnt   out  CNT_W  words accepted in the current or last job
// BEHAVIOUR
//   Reset (rst=0, asynchronous):
//     - CA state = SEED_DEFAULT; FSM = IDLE.
//     - out_valid, busy and done = 0; out_data and word_cnt = 0.
//   CA step, with q[-1] = q[WIDTH] = 0:
//     - q'[i] = q[i-1]^q[i+1], or q[i-1]^q[i]^q[i+1] when RULE150_MASK[i]=1.
//     - The CA advances only in STEP. It holds in all other states.
//   Seed load:
//     - In IDLE, seed_load=1 loads seed at the next edge. seed==0 loads SEED_DEFAULT instead.
//     - seed_load is ignored outside IDLE.
//     - seed_load and start in the same IDLE cycle: the load happens at that edge and the job starts from the new seed.
//   FSM states: IDLE, STEP, PRESENT, DONE.
//     - IDLE -> STEP on start. Latch num_words; clear word_cnt; load stride counter with STRIDE.
//     - STEP: advance the CA once per cycle. After the STRIDE-th advance, copy the new state to out_data and go to PRESENT.
//     - PRESENT: out_valid=1.
//       - out_data and out_valid hold while out_ready=0.
//       - On out_valid&&out_ready, word_cnt increments.
//       - If num_words!=0 and word_cnt+1==num_words, go to DONE. Otherwise go to STEP and reload the stride counter.
//     - DONE: done=1 for exactly one cycle, then IDLE. word_cnt holds its final value.
//   Latency and throughput:
//     - out_valid rises STRIDE edges after the edge that samples start.
//     - Back-to-back rate with out_ready=1: 1 word per STRIDE+1 cycles.
//   abort (highest priority, any state except IDLE):
//     - Next edge goes to IDLE; out_valid drops; done is not pulsed.
//     - The CA state and word_cnt are retained.
//     - abort in the same cycle as a handshake: the word counts, then abort wins (no DONE).
//   Other rules:
//     - start while busy is ignored.
//     - word_cnt wraps modulo 2^CNT_W in free-run.
//     - out_data is never 0 unless the CA reaches 0; a nonzero seed cannot reach 0 for the default mask.
// TESTING
//   1. Reset, start, num_words=2, STRIDE=1, out_ready=1 -> out_data 16'h0003 then 16'h0006; done pulses once; word_cnt=2.
//   2. seed_load with seed=0 in IDLE, then start -> first word equals the scenario-1 first word (state was 16'h0001).
//   3. out_ready held 0 for 5 cycles in PRESENT -> out_valid and out_data stable; no CA advance; word_cnt unchanged.
//   4. num_words=0 free-run for 1000 words vs golden C model, random ready -> bit-exact sequence; abort -> IDLE with no done.
//   5. rst low mid-STEP and mid-PRESENT -> outputs zero immediately, CA=SEED_DEFAULT; start after release reproduces scenario 1.
//   6. STRIDE=4, WIDTH=8, RULE150_MASK=8'h96 -> valid period 5 cycles; words match the golden model stepped 4x.

Source files
------------

// File: rtl/ca_prng_gen_if.sv
// ============================================================================
//  Module   : ca_prng_gen_if
//  Purpose  : Output word handshake bundle of the CA pseudo-random generator.
//             The generator drives the master side; the consumer (operand
//             feeder of the multiplier under test) uses the slave side.
//  Signals  : out_valid  master->slave  a new word is presented
//             out_ready  slave->master  consumer accepts the word this cycle
//             out_data   master->slave  generated word (WIDTH bits)
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface ca_prng_gen_if #(
  parameter int WIDTH = 16
) ();

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  modport master (
    output out_valid,
    output out_data,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    output out_ready
  );

endinterface

`default_nettype wire

// File: rtl/ca_prng_gen.sv
// ============================================================================
//  Module   : ca_prng_gen
//  Purpose  : Hybrid rule-90/150 cellular-automaton word generator with null
//             boundaries, per-cell rule mask and loadable seed. A job FSM
//             advances the CA STRIDE steps per word and presents each word
//             over a valid/ready handshake.
//  Ports    : clk        rising-edge clock
//             rst        asynchronous active-low reset
//             seed_load  load seed into the CA (IDLE only)
//             seed       seed value (zero selects SEED_DEFAULT)
//             start      begin a job (IDLE only)
//             num_words  words per job, 0 = free-run until abort
//             abort      terminate the current job, no done pulse
//             out_if     master side of the word handshake
//             busy       FSM not in IDLE
//             done       one-cycle pulse on normal job completion
//             word_cnt   words accepted in the current or last job
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module ca_prng_gen #(
  parameter int               WIDTH        = 16,
  parameter logic [WIDTH-1:0] RULE150_MASK = 16'h5555,
  parameter logic [WIDTH-1:0] SEED_DEFAULT = 16'h0001,
  parameter int               STRIDE       = 1,
  parameter int               CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed,
  input  logic             start,
  input  logic [CNT_W-1:0] num_words,
  input  logic             abort,
  ca_prng_gen_if.master    out_if,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] word_cnt
);

  // Stride counter counts down from STRIDE to 1; the advance taken while it
  // reads 1 is the last one for the current word.
  localparam int               SC_W      = $clog2(STRIDE + 1);
  localparam logic [SC_W-1:0]  STRIDE_LD = SC_W'(STRIDE);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_STEP    = 2'd1,
    S_PRESENT = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t           state_q,     state_d;
  logic [WIDTH-1:0] ca_q,        ca_d;
  logic [WIDTH-1:0] out_data_q,  out_data_d;
  logic [CNT_W-1:0] word_cnt_q,  word_cnt_d;
  logic [CNT_W-1:0] num_words_q, num_words_d;
  logic [SC_W-1:0]  stride_q,    stride_d;

  logic [WIDTH-1:0] ca_next;
  logic [WIDTH+1:0] ca_pad;
  logic [WIDTH-1:0] seed_eff;

  // -------------------------------------------------------------------------
  // One CA step. Zero cells are padded on both ends (null boundaries), so
  // cell i sees its left neighbour at ca_pad[i] and its right at ca_pad[i+2].
  // -------------------------------------------------------------------------
  assign ca_pad = {1'b0, ca_q, 1'b0};

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    if (RULE150_MASK[i]) begin : g_rule150
      assign ca_next[i] = ca_pad[i] ^ ca_pad[i+1] ^ ca_pad[i+2];
    end else begin : g_rule90
      assign ca_next[i] = ca_pad[i] ^ ca_pad[i+2];
    end
  end

  // An all-zero state is a fixed point of the CA, so it is never loaded.
  assign seed_eff = (seed == '0) ? SEED_DEFAULT : seed;

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    ca_d        = ca_q;
    out_data_d  = out_data_q;
    word_cnt_d  = word_cnt_q;
    num_words_d = num_words_q;
    stride_d    = stride_q;

    case (state_q)
      S_IDLE: begin
        // Load and start may coincide: the job then runs from the new seed.
        if (seed_load) begin
          ca_d = seed_eff;
        end
        if (start) begin
          state_d     = S_STEP;
          num_words_d = num_words;
          word_cnt_d  = '0;
          stride_d    = STRIDE_LD;
        end
      end

      S_STEP: begin
        ca_d = ca_next;
        if (stride_q == SC_W'(1)) begin
          out_data_d = ca_next;
          state_d    = S_PRESENT;
        end else begin
          stride_d = stride_q - SC_W'(1);
        end
      end

      S_PRESENT: begin
        if (out_if.out_ready) begin
          word_cnt_d = word_cnt_q + CNT_W'(1);
          if ((num_words_q != '0) && (word_cnt_q + CNT_W'(1) == num_words_q)) begin
            state_d = S_DONE;
          end else begin
            state_d  = S_STEP;
            stride_d = STRIDE_LD;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort overrides the transition but keeps any word counted this cycle;
    // the CA and presented word are frozen rather than advanced.
    if (abort && (state_q != S_IDLE)) begin
      state_d    = S_IDLE;
      ca_d       = ca_q;
      out_data_d = out_data_q;
    end
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      ca_q        <= SEED_DEFAULT;
      out_data_q  <= '0;
      word_cnt_q  <= '0;
      num_words_q <= '0;
      stride_q    <= STRIDE_LD;
    end else begin
      state_q     <= state_d;
      ca_q        <= ca_d;
      out_data_q  <= out_data_d;
      word_cnt_q  <= word_cnt_d;
      num_words_q <= num_words_d;
      stride_q    <= stride_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign out_if.out_valid = (state_q == S_PRESENT);
  assign out_if.out_data  = out_data_q;
  assign busy             = (state_q != S_IDLE);
  assign done             = (state_q == S_DONE);
  assign word_cnt         = word_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_ca_prng_gen.sv
// ============================================================================
//  Module   : tb_ca_prng_gen
//  Purpose  : Directed self-checking bench for ca_prng_gen. Two instances:
//             a 16-bit STRIDE=1 generator with the default mask, and an 8-bit
//             STRIDE=4 generator with mask 8'h96.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ca_prng_gen;

  logic clk;
  logic rst;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 16-bit instance
  logic        a_seed_load, a_start, a_abort;
  logic [15:0] a_seed, a_num;
  logic        a_busy, a_done;
  logic [15:0] a_cnt;

  ca_prng_gen_if #(.WIDTH(16)) a_if ();

  ca_prng_gen #(
    .WIDTH(16), .RULE150_MASK(16'h5555), .SEED_DEFAULT(16'h0001),
    .STRIDE(1), .CNT_W(16)
  ) u_dut_a (
    .clk(clk), .rst(rst),
    .seed_load(a_seed_load), .seed(a_seed), .start(a_start),
    .num_words(a_num), .abort(a_abort), .out_if(a_if),
    .busy(a_busy), .done(a_done), .word_cnt(a_cnt)
  );

  // 8-bit instance
  logic       b_seed_load, b_start, b_abort;
  logic [7:0] b_seed, b_num;
  logic       b_busy, b_done;
  logic [7:0] b_cnt;

  ca_prng_gen_if #(.WIDTH(8)) b_if ();

  ca_prng_gen #(
    .WIDTH(8), .RULE150_MASK(8'h96), .SEED_DEFAULT(8'h01),
    .STRIDE(4), .CNT_W(8)
  ) u_dut_b (
    .clk(clk), .rst(rst),
    .seed_load(b_seed_load), .seed(b_seed), .start(b_start),
    .num_words(b_num), .abort(b_abort), .out_if(b_if),
    .busy(b_busy), .done(b_done), .word_cnt(b_cnt)
  );

  int n_vec;
  int n_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference CA step: cell i = left ^ right, plus itself for rule-150 cells.
  function automatic logic [15:0] ca_step(input logic [15:0] q, input logic [15:0] mask,
                                          input int w);
    logic [15:0] n;
    logic        l, r;
    n = '0;
    for (int i = 0; i < w; i++) begin
      l    = (i > 0)     ? q[i-1] : 1'b0;
      r    = (i < w - 1) ? q[i+1] : 1'b0;
      n[i] = l ^ r ^ (mask[i] & q[i]);
    end
    return n;
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  // Two-word job from the default seed, consumer always ready.
  task automatic job_two_words(input string pfx);
    a_num = 16'd2; a_if.out_ready = 1'b1; a_start = 1'b1;
    tick(); a_start = 1'b0;
    check({pfx, "_busy"}, a_busy, 1'b1);
    check({pfx, "_step_nvalid"}, a_if.out_valid, 1'b0);
    tick();
    check({pfx, "_w0_valid"}, a_if.out_valid, 1'b1);
    check({pfx, "_w0"}, a_if.out_data, 16'h0003);
    tick();
    check({pfx, "_cnt1"}, a_cnt, 16'd1);
    tick();
    check({pfx, "_w1_valid"}, a_if.out_valid, 1'b1);
    check({pfx, "_w1"}, a_if.out_data, 16'h0006);
    tick();
    check({pfx, "_done"}, a_done, 1'b1);
    check({pfx, "_cnt2"}, a_cnt, 16'd2);
    tick();
    check({pfx, "_done_once"}, a_done, 1'b0);
    check({pfx, "_idle"}, a_busy, 1'b0);
    check({pfx, "_cnt_hold"}, a_cnt, 16'd2);
  endtask

  logic [15:0] m;
  logic [15:0] mb;
  int          words;
  int          cycles;

  initial begin
    n_vec = 0; n_err = 0;
    rst = 1'b0;
    a_seed_load = 1'b0; a_start = 1'b0; a_abort = 1'b0; a_seed = '0; a_num = '0;
    b_seed_load = 1'b0; b_start = 1'b0; b_abort = 1'b0; b_seed = '0; b_num = '0;
    a_if.out_ready = 1'b0; b_if.out_ready = 1'b0;
    repeat (3) tick();

    // Reset state
    check("rst_valid", a_if.out_valid, 1'b0);
    check("rst_busy", a_busy, 1'b0);
    check("rst_done", a_done, 1'b0);
    check("rst_data", a_if.out_data, 16'h0000);
    check("rst_cnt", a_cnt, 16'h0000);
    check("rst_b_busy", b_busy, 1'b0);
    rst = 1'b1;
    tick();

    // Basic two-word job
    job_two_words("s1");

    // Zero seed loads the default seed
    a_seed = 16'h0000; a_seed_load = 1'b1;
    tick(); a_seed_load = 1'b0;
    a_num = 16'd1; a_start = 1'b1; a_if.out_ready = 1'b1;
    tick(); a_start = 1'b0;
    tick();
    check("s2_valid", a_if.out_valid, 1'b1);
    check("s2_word", a_if.out_data, 16'h0003);
    tick();
    check("s2_done", a_done, 1'b1);
    check("s2_cnt", a_cnt, 16'd1);
    tick();

    // Seed load and start on the same edge: 0x8000 steps to 0x4000
    a_seed = 16'h8000; a_seed_load = 1'b1; a_start = 1'b1; a_num = 16'd1;
    tick(); a_seed_load = 1'b0; a_start = 1'b0;
    tick();
    check("s2b_word", a_if.out_data, 16'h4000);
    tick(); tick();
    m = 16'h4000;

    // Consumer stall; seed_load outside IDLE is ignored
    a_if.out_ready = 1'b0; a_num = 16'd3; a_start = 1'b1;
    tick(); a_start = 1'b0;
    tick();
    m = ca_step(m, 16'h5555, 16);
    check("s3_hand", a_if.out_data, 16'hE000);
    a_seed = 16'hFFFF; a_seed_load = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("s3_stall_valid", a_if.out_valid, 1'b1);
      check("s3_stall_data", a_if.out_data, m);
      check("s3_stall_cnt", a_cnt, 16'd0);
    end
    a_seed_load = 1'b0; a_if.out_ready = 1'b1;
    tick();
    check("s3_after_valid", a_if.out_valid, 1'b0);
    check("s3_after_cnt", a_cnt, 16'd1);
    tick();
    m = ca_step(m, 16'h5555, 16);
    check("s3_w1", a_if.out_data, m);
    // Abort together with a handshake: the word counts, no DONE
    a_abort = 1'b1;
    tick(); a_abort = 1'b0;
    check("s3_abort_busy", a_busy, 1'b0);
    check("s3_abort_done", a_done, 1'b0);
    check("s3_abort_cnt", a_cnt, 16'd2);
    check("s3_abort_valid", a_if.out_valid, 1'b0);
    tick();
    check("s3_abort_nodone", a_done, 1'b0);

    // Free-run with random ready against the reference model
    a_num = 16'd0; a_start = 1'b1;
    tick(); a_start = 1'b0;
    words = 0; cycles = 0;
    while (words < 1000 && cycles < 20000) begin
      a_if.out_ready = 1'($urandom_range(0, 1));
      if (a_if.out_valid && a_if.out_ready) begin
        m = ca_step(m, 16'h5555, 16);
        check("s4_word", a_if.out_data, m);
        words++;
      end
      tick();
      cycles++;
    end
    if (words < 1000) check("s4_timeout", 32'(words), 32'd1000);
    check("s4_cnt", a_cnt, 16'd1000);
    a_if.out_ready = 1'b0; a_abort = 1'b1;
    tick(); a_abort = 1'b0;
    check("s4_abort_busy", a_busy, 1'b0);
    check("s4_abort_done", a_done, 1'b0);
    check("s4_abort_cnt", a_cnt, 16'd1000);

    // Asynchronous reset mid-STEP and mid-PRESENT
    a_num = 16'd2; a_start = 1'b1;
    tick(); a_start = 1'b0;
    #2 rst = 1'b0;
    #1;
    check("s5_step_busy", a_busy, 1'b0);
    check("s5_step_data", a_if.out_data, 16'h0000);
    check("s5_step_cnt", a_cnt, 16'h0000);
    tick(); rst = 1'b1;
    tick();
    a_start = 1'b1;
    tick(); a_start = 1'b0;
    tick();
    check("s5_present_valid", a_if.out_valid, 1'b1);
    #2 rst = 1'b0;
    #1;
    check("s5_pres_valid", a_if.out_valid, 1'b0);
    check("s5_pres_busy", a_busy, 1'b0);
    check("s5_pres_data", a_if.out_data, 16'h0000);
    tick(); rst = 1'b1;
    tick();
    job_two_words("s5_rerun");

    // 8-bit, STRIDE=4, mask 8'h96: one word every 5 cycles
    mb = 16'h0001;
    b_num = 8'd3; b_if.out_ready = 1'b1; b_start = 1'b1;
    tick(); b_start = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      check("s6_valid", b_if.out_valid, (k % 5 == 0));
      if (k % 5 == 0) begin
        repeat (4) mb = ca_step(mb, 16'h0096, 8);
        check("s6_word", b_if.out_data, mb);
        if (k == 5) check("s6_hand", b_if.out_data, 8'h11);
      end
      tick();
    end
    check("s6_done", b_done, 1'b1);
    check("s6_cnt", b_cnt, 8'd3);
    tick();
    check("s6_idle", b_busy, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
